// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// Shared definitions for the IFU/LSU read arbiter: port IDs, FSM states,
// AXI response codes and default widths.
package ysyx_22041071_axi_rd_arb_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int LEN_W_DEF  = 8;
   localparam int ID_W_DEF   = 4;

   // Requester index doubles as the AXI ID issued to the engine
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } state_t;

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the port that did not win last time.
module ysyx_22041071_rr_arb2
   import ysyx_22041071_axi_rd_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_vld,
   output logic       gnt
);

   // Winner index; only meaningful while gnt_vld is high
   always_comb begin
      gnt_vld = |req;
      if (&req) gnt = ~last_gnt;
      else      gnt = req[PORT_LS] ? PORT_LS : PORT_IF;
   end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Shares one AXI read engine between IFU (port 0) and LSU (port 1).
// One transaction in flight; returned beats are steered to the granted port
// with no added latency.
module ysyx_22041071_axi_rd_arb
   import ysyx_22041071_axi_rd_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ID_W   = ID_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic [1:0]        if_size,
   input  logic [LEN_W-1:0]  if_len,
   output logic              if_ready,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic [1:0]        if_rresp,
   output logic              if_rlast,
   input  logic              ls_valid,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [1:0]        ls_size,
   input  logic [LEN_W-1:0]  ls_len,
   output logic              ls_ready,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [1:0]        ls_rresp,
   output logic              ls_rlast,
   output logic              m_ar_valid,
   input  logic              m_ar_ready,
   output logic [ID_W-1:0]   m_id,
   output logic [ADDR_W-1:0] m_addr,
   output logic [1:0]        m_size,
   output logic [LEN_W-1:0]  m_len,
   input  logic              m_r_valid,
   input  logic [DATA_W-1:0] m_r_data,
   input  logic [1:0]        m_r_resp,
   output logic              spurious_o
);

   state_t            state, state_nx;
   logic              grant, last_gnt;
   logic [LEN_W-1:0]  beat_cnt;
   logic              arb_vld, arb_gnt;
   logic              accept, handshake, beat, last_beat;

   ysyx_22041071_rr_arb2 u_arb (
      .req      ({ls_valid, if_valid}),
      .last_gnt (last_gnt),
      .gnt_vld  (arb_vld),
      .gnt      (arb_gnt)
   );

   assign accept    = (state == ST_IDLE) && arb_vld;
   assign handshake = (state == ST_ISSUE) && m_ar_ready;
   assign beat      = (state == ST_DATA) && m_r_valid;
   // Compare before increment so len = all-ones never needs a wider counter
   assign last_beat = beat && (beat_cnt == m_len);

   // Next-state logic for the IDLE -> ISSUE -> DATA -> IDLE cycle
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (arb_vld)    state_nx = ST_ISSUE;
         ST_ISSUE: if (m_ar_ready) state_nx = ST_DATA;
         ST_DATA:  if (last_beat)  state_nx = ST_IDLE;
         default:                  state_nx = ST_IDLE;
      endcase
   end

   // State, request latch, beat counter and sticky spurious-beat flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         grant      <= PORT_IF;
         last_gnt   <= PORT_IF;
         beat_cnt   <= '0;
         m_addr     <= '0;
         m_size     <= '0;
         m_len      <= '0;
         spurious_o <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            grant  <= arb_gnt;
            m_addr <= (arb_gnt == PORT_LS) ? ls_addr : if_addr;
            m_size <= (arb_gnt == PORT_LS) ? ls_size : if_size;
            m_len  <= (arb_gnt == PORT_LS) ? ls_len  : if_len;
         end
         if (handshake) begin
            last_gnt <= grant;
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         // Beats outside DATA are dropped but remembered for debug
         if (m_r_valid && (state != ST_DATA)) spurious_o <= 1'b1;
      end
   end

   assign m_id = {{(ID_W-1){1'b0}}, grant};

   // Request handshake and response demux; held quiet while reset is low
   always_comb begin
      m_ar_valid = reset_n && (state == ST_ISSUE);
      if_ready   = reset_n && accept && (arb_gnt == PORT_IF);
      ls_ready   = reset_n && accept && (arb_gnt == PORT_LS);
      if_rvalid  = reset_n && beat && (grant == PORT_IF);
      ls_rvalid  = reset_n && beat && (grant == PORT_LS);
      if_rdata   = if_rvalid ? m_r_data : '0;
      if_rresp   = if_rvalid ? m_r_resp : 2'b00;
      if_rlast   = if_rvalid && last_beat;
      ls_rdata   = ls_rvalid ? m_r_data : '0;
      ls_rresp   = ls_rvalid ? m_r_resp : 2'b00;
      ls_rlast   = ls_rvalid && last_beat;
   end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Randomized + directed bench for the IFU/LSU read arbiter with a
// transaction-level reference model checked every cycle.
module tb_ysyx_22041071_axi_rd_arb;
   import ysyx_22041071_axi_rd_arb_pkg::*;

   localparam int AW = 64, DW = 64, LW = 8, IW = 4;

   logic          clk = 1'b0, reset_n = 1'b0;
   logic          if_valid = 0, ls_valid = 0;
   logic [AW-1:0] if_addr = '0, ls_addr = '0;
   logic [1:0]    if_size = '0, ls_size = '0;
   logic [LW-1:0] if_len = '0, ls_len = '0;
   logic          if_ready, ls_ready, if_rvalid, ls_rvalid, if_rlast, ls_rlast;
   logic [DW-1:0] if_rdata, ls_rdata;
   logic [1:0]    if_rresp, ls_rresp;
   logic          m_ar_valid, m_ar_ready = 0, m_r_valid = 0, spurious_o;
   logic [IW-1:0] m_id;
   logic [AW-1:0] m_addr;
   logic [1:0]    m_size, m_r_resp = '0;
   logic [LW-1:0] m_len;
   logic [DW-1:0] m_r_data = '0;

   int total = 0, bad = 0;
   int ifb = 0, ifl = 0, lsb = 0, lsl = 0;

   ysyx_22041071_axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_len(if_len),
      .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .if_rresp(if_rresp), .if_rlast(if_rlast),
      .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_size(ls_size), .ls_len(ls_len),
      .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .ls_rresp(ls_rresp), .ls_rlast(ls_rlast),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_id(m_id),
      .m_addr(m_addr), .m_size(m_size), .m_len(m_len),
      .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
      .spurious_o(spurious_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Reference model: transaction phase (0 idle, 1 address, 2 data),
   // granted port, beats still owed, previous winner, latched request.
   int            mph = 0, mrem = 0;
   bit            mg = 0, mlast = 0, mspur = 0;
   logic [AW-1:0] maddr = '0;
   logic [1:0]    msize = '0;
   logic [LW-1:0] mlen = '0;

   // Compare DUT against model, then advance model across the coming edge
   always @(negedge clk) begin
      bit w, e_ifr, e_lsr, e_arv, e_rv, e_rl;
      w = 0; e_ifr = 0; e_lsr = 0; e_arv = 0; e_rv = 0; e_rl = 0;
      if (reset_n) begin
         if (mph == 0 && (if_valid || ls_valid)) begin
            w = (if_valid && ls_valid) ? !mlast : ls_valid;
            e_ifr = !w; e_lsr = w;
         end
         e_arv = (mph == 1);
         if (mph == 2 && m_r_valid) begin e_rv = 1; e_rl = (mrem == 1); end
      end
      chk("if_ready", if_ready, e_ifr);
      chk("ls_ready", ls_ready, e_lsr);
      chk("m_ar_valid", m_ar_valid, e_arv);
      chk("m_id", m_id, {3'b0, mg});
      chk("m_addr", m_addr, maddr);
      chk("m_size", m_size, msize);
      chk("m_len", m_len, mlen);
      chk("if_rvalid", if_rvalid, e_rv && !mg);
      chk("ls_rvalid", ls_rvalid, e_rv && mg);
      chk("if_rdata", if_rdata, (e_rv && !mg) ? m_r_data : '0);
      chk("ls_rdata", ls_rdata, (e_rv && mg) ? m_r_data : '0);
      chk("if_rresp", if_rresp, (e_rv && !mg) ? m_r_resp : 2'b00);
      chk("ls_rresp", ls_rresp, (e_rv && mg) ? m_r_resp : 2'b00);
      chk("if_rlast", if_rlast, e_rl && !mg);
      chk("ls_rlast", ls_rlast, e_rl && mg);
      chk("spurious", spurious_o, mspur);
      if (!reset_n) begin
         mph = 0; mg = 0; mlast = 0; mrem = 0; mspur = 0;
         maddr = '0; msize = '0; mlen = '0;
      end else begin
         if (mph != 2 && m_r_valid) mspur = 1;
         case (mph)
            0: if (if_valid || ls_valid) begin
                  mph = 1; mg = w;
                  maddr = w ? ls_addr : if_addr;
                  msize = w ? ls_size : if_size;
                  mlen  = w ? ls_len  : if_len;
               end
            1: if (m_ar_ready) begin mph = 2; mrem = int'(mlen) + 1; mlast = mg; end
            default: if (m_r_valid) begin
                  mrem--;
                  if (mrem == 0) mph = 0;
               end
         endcase
      end
   end

   // Beat/last counters for literal burst-shape checks
   always @(negedge clk) begin
      if (if_rvalid) ifb++;
      if (if_rlast)  ifl++;
      if (ls_rvalid) lsb++;
      if (ls_rlast)  lsl++;
   end

   // Engine stand-in: hold off address for ar_wait cycles, then stream beats
   task automatic engine_run(input int ar_wait, input int nbeats, input int err_beat);
      m_ar_ready = 0;
      repeat (ar_wait) begin
         @(negedge clk); chk("ar_hold", m_ar_valid, 1'b1);
         tick();
      end
      m_ar_ready = 1; tick(); m_ar_ready = 0;
      for (int i = 0; i < nbeats; i++) begin
         m_r_valid = 1; m_r_data = {$urandom, $urandom};
         m_r_resp = (i == err_beat) ? RESP_SLVERR : RESP_OKAY;
         if (i == err_beat) begin
            @(negedge clk); chk("err_resp", if_rresp | ls_rresp, RESP_SLVERR);
         end
         tick();
      end
      m_r_valid = 0; m_r_resp = 0;
   endtask

   initial begin
      int b0, l0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_outs", {m_ar_valid, spurious_o, if_ready, ls_ready, m_id}, '0);
      tick(); reset_n = 1;

      // IFU alone, single beat
      if_valid = 1; if_addr = 64'h8000_0000; if_size = 2'b11; if_len = 0;
      @(negedge clk); chk("t1_if_ready", if_ready, 1'b1);
      tick(); if_valid = 0;
      @(negedge clk); chk("t1_m_id", m_id, 0); chk("t1_m_addr", m_addr, 64'h8000_0000);
      b0 = ifb; l0 = ifl;
      engine_run(0, 1, -1);
      chk("t1_beats", ifb - b0, 1); chk("t1_rlast", ifl - l0, 1); chk("t1_ls_quiet", lsb, 0);

      // Two ties in a row alternate LSU then IFU
      for (int k = 0; k < 2; k++) begin
         if_valid = 1; ls_valid = 1; if_addr = 64'h1000 + k; ls_addr = 64'h2000 + k;
         if_len = 0; ls_len = 0;
         @(negedge clk); chk("tie_ready", {ls_ready, if_ready}, (k == 0) ? 2'b10 : 2'b01);
         tick(); if_valid = 0; ls_valid = 0;
         @(negedge clk); chk("tie_m_id", m_id, (k == 0) ? 1 : 0);
         engine_run(0, 1, -1);
      end

      // LSU 4-beat burst with IFU waiting the whole time
      ls_valid = 1; ls_addr = 64'h3000; ls_len = 3; ls_size = 2'b10;
      tick(); ls_valid = 0; if_valid = 1; if_addr = 64'h4000; if_len = 0;
      b0 = lsb; l0 = lsl;
      engine_run(0, 4, -1);
      chk("t3_beats", lsb - b0, 4); chk("t3_rlast", lsl - l0, 1);
      @(negedge clk); chk("t3_if_after", if_ready, 1'b1);
      tick(); if_valid = 0;
      // Engine stalls the address for 5 cycles
      engine_run(5, 1, -1);

      // Error response on first beat of a 2-beat burst
      ls_valid = 1; ls_addr = 64'h5000; ls_len = 1;
      tick(); ls_valid = 0;
      b0 = lsb; l0 = lsl;
      engine_run(1, 2, 0);
      chk("t5_beats", lsb - b0, 2); chk("t5_rlast", lsl - l0, 1);

      // Random traffic; engine only returns beats during the model's data phase
      for (int c = 0; c < 3000; c++) begin
         if_valid = ($urandom % 3 == 0); ls_valid = ($urandom % 3 == 0);
         if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
         if_size = 2'($urandom); ls_size = 2'($urandom);
         if_len = ($urandom % 60 == 0) ? 8'hFF : 8'($urandom_range(0, 3));
         ls_len = 8'($urandom_range(0, 3));
         m_ar_ready = 1'($urandom);
         m_r_valid = (mph == 2) ? 1'($urandom) : 1'b0;
         m_r_data = {$urandom, $urandom}; m_r_resp = 2'($urandom);
         tick();
      end
      if_valid = 0; ls_valid = 0; m_ar_ready = 1;
      for (int c = 0; c < 600 && mph != 0; c++) begin
         m_r_valid = (mph == 2); tick();
      end
      m_r_valid = 0; m_ar_ready = 0;
      chk("drain_idle", mph, 0);
      tick();

      // Reset in the middle of a 4-beat LSU burst, then a stray beat
      ls_valid = 1; ls_addr = 64'h6000; ls_len = 3;
      tick(); ls_valid = 0;
      m_ar_ready = 1; tick(); m_ar_ready = 0;
      m_r_valid = 1; tick();
      reset_n = 0;
      l0 = lsl;
      @(negedge clk); chk("rst_mid_quiet", {ls_rvalid, ls_rlast, m_ar_valid}, 3'b000);
      tick(); reset_n = 1;
      @(negedge clk); chk("rst_spur_clr", spurious_o, 1'b0); chk("rst_idle_quiet", ls_rvalid, 1'b0);
      tick(); m_r_valid = 0;
      @(negedge clk); chk("spur_set", spurious_o, 1'b1); chk("rst_no_rlast", lsl - l0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
